serial_bit_adder: RTL and testbench

//  Bit-serial W-bit adder built around the 1-bit half-adder cell: loads two operands plus carry-in,

---
 rtl/serial_bit_adder_pkg.sv | 9 +
 rtl/serial_bit_adder_ha_cell.sv | 10 +
 rtl/serial_bit_adder.sv | 80 ++++++++
 tb/tb_serial_bit_adder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/serial_bit_adder_pkg.sv
// serial_bit_adder_pkg: shared FSM state encoding and width limit for the bit-serial adder
package serial_bit_adder_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
  localparam int MIN_W = 2;
endpackage

// File: rtl/serial_bit_adder_ha_cell.sv
// ha_cell: 1-bit half adder, sum and carry of two bits
module ha_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

// File: rtl/serial_bit_adder.sv
// serial_bit_adder: W-bit adder processing one bit pair per cycle, LSB first
module serial_bit_adder
  import serial_bit_adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:1]  r_sum_sh;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_sum;
  logic          r_cout;
  logic          w_p;
  logic          w_g;
  logic          w_s;
  logic          w_pc;
  logic          w_c;
  logic [W-1:0]  w_sum_next;
  ha_cell u_ha0 (.i_a(r_a[0]), .i_b(r_b[0]),  .o_s(w_p), .o_c(w_g));
  ha_cell u_ha1 (.i_a(w_p),    .i_b(r_carry), .o_s(w_s), .o_c(w_pc));
  assign w_c = w_g | w_pc;
  // The lowest collected bit is always shifted out, so only W-1 bits are stored
  assign w_sum_next = {w_s, r_sum_sh};
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign sum  = r_sum;
  assign cout = r_cout;
  // FSM: load operands, shift one bit per cycle, publish result on entry to DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        SHIFT: begin
          r_carry  <= w_c;
          r_sum_sh <= w_sum_next[W-1:1];
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_sum   <= w_sum_next;
            r_cout  <= w_c;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_serial_bit_adder.sv
// tb_serial_bit_adder: scoreboard bench for the bit-serial adder
module tb_serial_bit_adder;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [W:0]   q_exp[$];
  int           q_acc[$];
  logic [W:0]   last = '0;

  serial_bit_adder #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input int acc);
    q_exp.push_back({1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc});
    q_acc.push_back(acc);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4 * W && q_exp.size() != 0; i++) @(negedge clk);
    if (q_exp.size() != 0) begin
      check("drain_timeout", q_exp.size(), 0);
      q_exp.delete();
      q_acc.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push(ta, tb_, tc, cyc);
    a = ~ta; b = tb_ ^ 8'h5A; cin = ~tc;
    check("busy_after_start", busy, 1);
    check("hold_prev", {cout, sum}, last);
    wait_drain();
  endtask

  initial begin : monitor
    logic prev_done;
    logic [W:0] e;
    int ac;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_done = 1'b0;
      else begin
        if (prev_done) check("done_pulse", done, 0);
        if (done) begin
          if (q_exp.size() == 0) check("spurious_done", 1, 0);
          else begin
            e = q_exp.pop_front();
            ac = q_acc.pop_front();
            check("sum", sum, e[W-1:0]);
            check("cout", cout, e[W]);
            check("latency", cyc - ac, W);
            last = e;
          end
        end
        prev_done = done;
      end
    end
  end

  initial begin : stim
    int acc;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_add(8'h0F, 8'h01, 1'b0);
    run_add(8'hFF, 8'h01, 1'b0);
    run_add(8'hFF, 8'hFF, 1'b1);
    run_add(8'h00, 8'h00, 1'b1);
    // start held high with operands changed mid-add
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    acc = cyc;
    push(8'h0F, 8'h01, 1'b0, acc);
    a = 8'hAA; b = 8'h55; cin = 1'b1;
    push(8'hAA, 8'h55, 1'b1, acc + W + 2);
    repeat (W + 1) @(negedge clk);
    check("busy_gap", busy, 0);
    @(negedge clk);
    check("busy_reaccept", busy, 1);
    start = 1'b0;
    wait_drain();
    // asynchronous reset in the middle of an add
    @(negedge clk);
    a = 8'h77; b = 8'h99; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
    push(8'h77, 8'h99, 1'b1, acc);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    void'(q_exp.pop_back());
    void'(q_acc.pop_back());
    last = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * W) @(negedge clk);
    run_add(8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 40; i++)
      run_add(W'($urandom), W'($urandom), 1'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
